// File: rtl/seg_dec_collect.sv
// seg_dec_collect: turns a stream of 7-segment patterns back into BCD digits
// and packs each host-delimited frame into one word with a valid/ready output.
//
// Ports:
//   iClk, iRst_n             clock, synchronous active-low reset
//   iSeg, iSegValid,         segment pattern input (a..g = bit7..bit1,
//   iSegLast, oSegReady      dp = bit0, ignored), last-of-frame marker, ready
//   oBcd, oDigitCnt,         committed frame: packed BCD (newest digit in
//   oErr, oOvf               [3:0]), digit count, undecodable flag, overflow
//   oFrameValid, iFrameReady output handshake, held until accepted
module seg_dec_collect #(
   parameter int DIGITS = 4,
   parameter int CW     = 3
) (
   input  logic                  iClk,
   input  logic                  iRst_n,
   input  logic [7:0]            iSeg,
   input  logic                  iSegValid,
   input  logic                  iSegLast,
   output logic                  oSegReady,
   output logic [4*DIGITS-1:0]   oBcd,
   output logic [CW-1:0]         oDigitCnt,
   output logic                  oErr,
   output logic                  oOvf,
   output logic                  oFrameValid,
   input  logic                  iFrameReady
);

   localparam int BW = 4 * DIGITS;
   localparam logic [CW-1:0] CMAX = CW'(DIGITS);

   typedef enum logic {
      COLLECT,
      HOLD
   } state_t;

   state_t          state;
   logic [BW-1:0]   acc;
   logic [CW-1:0]   cnt;
   logic            err;
   logic            ovf;

   logic [6:0]      seg7;
   logic [3:0]      nib;
   logic            bad;
   logic [BW-1:0]   acc_nx;
   logic [CW-1:0]   cnt_nx;
   logic            err_nx;
   logic            ovf_nx;
   logic            unused_dp;

   assign seg7      = iSeg[7:1];
   assign unused_dp = iSeg[0];
   assign oSegReady = (state == COLLECT);

   always_comb begin
      nib = 4'hF;
      unique case (1'b1)
         (seg7 == 7'h7E): nib = 4'd0;
         (seg7 == 7'h30): nib = 4'd1;
         (seg7 == 7'h6D): nib = 4'd2;
         (seg7 == 7'h79): nib = 4'd3;
         (seg7 == 7'h33): nib = 4'd4;
         (seg7 == 7'h5B): nib = 4'd5;
         (seg7 == 7'h5F): nib = 4'd6;
         (seg7 == 7'h70): nib = 4'd7;
         (seg7 == 7'h7F): nib = 4'd8;
         (seg7 == 7'h7B): nib = 4'd9;
         default:         nib = 4'hF;
      endcase
   end

   assign bad = (nib == 4'hF);

   // A one-digit accumulator has nothing older to shift up.
   generate
      if (BW > 4) begin : g_shift
         assign acc_nx = {acc[BW-5:0], nib};
      end else begin : g_single
         assign acc_nx = nib;
      end
   endgenerate

   // The counter saturates; a digit arriving at a full count
   // pushes the oldest one out and marks the frame as overflowed.
   assign cnt_nx = (cnt == CMAX) ? CMAX : cnt + CW'(1);
   assign ovf_nx = ovf | (cnt == CMAX);
   assign err_nx = err | bad;

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         state       <= COLLECT;
         acc         <= '0;
         cnt         <= '0;
         err         <= 1'b0;
         ovf         <= 1'b0;
         oBcd        <= '0;
         oDigitCnt   <= '0;
         oErr        <= 1'b0;
         oOvf        <= 1'b0;
         oFrameValid <= 1'b0;
      end else begin
         unique case (state)
            COLLECT: begin
               if (iSegValid) begin
                  if (iSegLast) begin
                     oBcd        <= acc_nx;
                     oDigitCnt   <= cnt_nx;
                     oErr        <= err_nx;
                     oOvf        <= ovf_nx;
                     oFrameValid <= 1'b1;
                     acc         <= '0;
                     cnt         <= '0;
                     err         <= 1'b0;
                     ovf         <= 1'b0;
                     state       <= HOLD;
                  end else begin
                     acc <= acc_nx;
                     cnt <= cnt_nx;
                     err <= err_nx;
                     ovf <= ovf_nx;
                  end
               end
            end
            HOLD: begin
               if (iFrameReady) begin
                  oFrameValid <= 1'b0;
                  state       <= COLLECT;
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_seg_dec_collect.sv
// tb_seg_dec_collect: scoreboard bench for seg_dec_collect.
// Directed frames first, then randomized frames with a random consumer.
module tb_seg_dec_collect;

   localparam int DIGITS = 4;
   localparam int CW     = 3;

   logic          iClk = 1'b0;
   logic          iRst_n = 1'b0;
   logic [7:0]    iSeg = 8'h00;
   logic          iSegValid = 1'b0;
   logic          iSegLast = 1'b0;
   logic          iFrameReady = 1'b0;
   logic          oSegReady;
   logic [15:0]   oBcd;
   logic [CW-1:0] oDigitCnt;
   logic          oErr;
   logic          oOvf;
   logic          oFrameValid;

   seg_dec_collect #(.DIGITS(DIGITS), .CW(CW)) dut (
      .iClk        (iClk),
      .iRst_n      (iRst_n),
      .iSeg        (iSeg),
      .iSegValid   (iSegValid),
      .iSegLast    (iSegLast),
      .oSegReady   (oSegReady),
      .oBcd        (oBcd),
      .oDigitCnt   (oDigitCnt),
      .oErr        (oErr),
      .oOvf        (oOvf),
      .oFrameValid (oFrameValid),
      .iFrameReady (iFrameReady)
   );

   always #5 iClk = ~iClk;

   typedef struct {
      logic [15:0] bcd;
      int          cnt;
      logic        err;
      logic        ovf;
   } exp_t;

   exp_t       exp_q[$];
   int         errors = 0;
   int         checks = 0;
   int         rdy_mode = 0;
   logic [7:0] pats [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                             8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Digit = position of the pattern in the table, dp masked off.
   function automatic int decode(input logic [7:0] b);
      for (int i = 0; i < 10; i++)
         if ((b | 8'h01) == (pats[i] | 8'h01)) return i;
      return 15;
   endfunction

   // Frame value: the last DIGITS digits read as a hex number.
   task automatic push_frame(input logic [7:0] bytes[$]);
      int   digs[$];
      exp_t e;
      e.err = 1'b0;
      foreach (bytes[i]) begin
         int d;
         d = decode(bytes[i]);
         if (d == 15) e.err = 1'b1;
         digs.push_back(d);
      end
      e.ovf = (bytes.size() > DIGITS);
      while (digs.size() > DIGITS) void'(digs.pop_front());
      e.cnt = digs.size();
      e.bcd = 16'h0;
      foreach (digs[i]) e.bcd = 16'(e.bcd * 16 + digs[i]);
      exp_q.push_back(e);
   endtask

   task automatic send(input logic [7:0] b, input bit last, input int gap);
      int n;
      for (int g = 0; g < gap; g++) begin
         iSegValid = 1'b0;
         iSegLast  = 1'($urandom_range(0, 1));
         iSeg      = 8'($urandom);
         @(negedge iClk);
      end
      iSeg      = b;
      iSegValid = 1'b1;
      iSegLast  = last;
      n = 0;
      while (!oSegReady && n < 200) begin
         @(negedge iClk);
         n++;
      end
      if (n >= 200) chk("seg_ready_timeout", 0, 1);
      @(negedge iClk);
      iSegValid = 1'b0;
      iSegLast  = 1'b0;
      if (last) chk("valid_latency", oFrameValid, 1);
   endtask

   task automatic send_frame(input logic [7:0] bytes[$], input int maxgap);
      push_frame(bytes);
      foreach (bytes[i])
         send(bytes[i], i == bytes.size() - 1, $urandom_range(0, maxgap));
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge iClk);
         n++;
      end
      chk("drain", exp_q.size(), 0);
   endtask

   task automatic release_frame();
      rdy_mode = 1;
      @(negedge iClk);
      chk("rel_valid", oFrameValid, 0);
      chk("rel_ready", oSegReady, 1);
      rdy_mode = 0;
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_bcd"}, oBcd, 0);
      chk({tag, "_cnt"}, oDigitCnt, 0);
      chk({tag, "_err"}, oErr, 0);
      chk({tag, "_ovf"}, oOvf, 0);
      chk({tag, "_valid"}, oFrameValid, 0);
   endtask

   // Consumer: drives iFrameReady just after each falling edge.
   initial begin
      forever begin
         @(negedge iClk);
         #1;
         if (rdy_mode == 2) iFrameReady = 1'($urandom_range(0, 1));
         else               iFrameReady = (rdy_mode == 1);
      end
   end

   // Monitor: each new frame presentation pops one expectation.
   initial begin
      logic prev_v;
      prev_v = 1'b0;
      forever begin
         @(negedge iClk);
         if (oFrameValid && !prev_v) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_frame", oBcd, 32'hDEAD);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("frame_bcd", oBcd, e.bcd);
               chk("frame_cnt", oDigitCnt, e.cnt);
               chk("frame_err", oErr, e.err);
               chk("frame_ovf", oOvf, e.ovf);
            end
         end
         prev_v = oFrameValid;
      end
   end

   initial begin
      logic [7:0]  fq[$];
      logic [15:0] held_bcd;

      repeat (3) @(negedge iClk);
      chk_cleared("reset");
      iRst_n = 1'b1;
      @(negedge iClk);
      chk("reset_ready", oSegReady, 1);

      fq = {8'h60, 8'hDA, 8'hF2};
      send_frame(fq, 0);
      wait_drain();
      release_frame();

      fq = {8'hFF, 8'hB6};
      send_frame(fq, 0);
      wait_drain();
      release_frame();

      fq = {8'h60, 8'h91, 8'hE0};
      send_frame(fq, 0);
      wait_drain();
      release_frame();

      fq = {8'hFC};
      send_frame(fq, 0);
      wait_drain();
      release_frame();

      fq = {8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6};
      send_frame(fq, 0);
      wait_drain();
      release_frame();

      fq = {8'h60};
      send_frame(fq, 0);
      wait_drain();
      held_bcd = oBcd;
      fq = {8'h7E};
      push_frame(fq);
      iSeg      = 8'h7E;
      iSegValid = 1'b1;
      iSegLast  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge iClk);
         chk("hold_ready", oSegReady, 0);
         chk("hold_valid", oFrameValid, 1);
         chk("hold_bcd", oBcd, held_bcd);
      end
      rdy_mode = 1;
      @(negedge iClk);
      chk("held_rel_valid", oFrameValid, 0);
      chk("held_rel_ready", oSegReady, 1);
      rdy_mode = 0;
      @(negedge iClk);
      chk("held_accept", oFrameValid, 1);
      iSegValid = 1'b0;
      iSegLast  = 1'b0;
      wait_drain();
      release_frame();

      send(8'h60, 1'b0, 0);
      send(8'hDA, 1'b0, 0);
      iRst_n = 1'b0;
      @(negedge iClk);
      iRst_n = 1'b1;
      chk("midrst_cnt", oDigitCnt, 0);
      chk("midrst_ready", oSegReady, 1);
      fq = {8'hF2};
      send_frame(fq, 0);
      wait_drain();
      release_frame();

      rdy_mode = 2;
      for (int f = 0; f < 40; f++) begin
         int len;
         len = $urandom_range(1, 6);
         fq = {};
         for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 9) < 7)
               fq.push_back(pats[$urandom_range(0, 9)] |
                            8'($urandom_range(0, 1)));
            else
               fq.push_back(8'($urandom));
         end
         send_frame(fq, 2);
      end
      wait_drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
